pc_redirect_ctrl: RTL and testbench

//   Producer side of the next-PC select interface. Holds the fetch PC and resolves redirect requests

---
 rtl/pc_redirect_ctrl.sv | 113 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC owner: resolves jump/branch/jr redirects into a one-hot next-PC select,
// buffers redirects that arrive while fetch is held, and raises IF/ID flushes.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic [2:0]  pc_sel,
    output logic [31:0] redirect_tgt,
    output logic        flush_if,
    output logic        flush_id
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_t;

    localparam logic [2:0] SEL_SEQ    = 3'b000;
    localparam logic [2:0] SEL_JUMP   = 3'b001;
    localparam logic [2:0] SEL_BRANCH = 3'b010;
    localparam logic [2:0] SEL_JR     = 3'b100;

    state_t      state;
    logic [2:0]  pend_sel;
    logic [31:0] pend_tgt;
    logic        pend_ex;
    logic        advance;

    always_comb begin
        advance = !stall && imem_ready && (state != BOOT);
        pend_ex = pend_sel[1] | pend_sel[2];
    end

    // EX redirects are older than the ID jump, so a buffered EX redirect
    // outranks a live jump, while a live jump replaces a buffered jump.
    always_comb begin
        pc_sel       = SEL_SEQ;
        redirect_tgt = 32'h0;
        if (branch_req) begin
            pc_sel       = SEL_BRANCH;
            redirect_tgt = branch_target;
        end else if (jr_req) begin
            pc_sel       = SEL_JR;
            redirect_tgt = jr_target;
        end else if (pend_ex) begin
            pc_sel       = pend_sel;
            redirect_tgt = pend_tgt;
        end else if (jump_req) begin
            pc_sel       = SEL_JUMP;
            redirect_tgt = jump_target;
        end else if (pend_sel[0]) begin
            pc_sel       = SEL_JUMP;
            redirect_tgt = pend_tgt;
        end
    end

    always_comb begin
        flush_if = advance && (pc_sel != SEL_SEQ);
        flush_id = advance && (pc_sel[1] || pc_sel[2]);
    end

    // Whenever fetch cannot advance, the current winning selection becomes
    // the pending redirect, which folds the overwrite rules into pc_sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            state       <= BOOT;
            pend_sel    <= SEL_SEQ;
            pend_tgt    <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    fetch_valid <= 1'b1;
                    if (pc_sel != SEL_SEQ) begin
                        pend_sel <= pc_sel;
                        pend_tgt <= redirect_tgt;
                        state    <= HOLD;
                    end else begin
                        state    <= RUN;
                    end
                end
                RUN, HOLD: begin
                    if (advance) begin
                        pc       <= (pc_sel != SEL_SEQ) ? redirect_tgt : pc + PC_STEP;
                        pend_sel <= SEL_SEQ;
                        pend_tgt <= 32'h0;
                        state    <= RUN;
                    end else if (pc_sel != SEL_SEQ) begin
                        pend_sel <= pc_sel;
                        pend_tgt <= redirect_tgt;
                        state    <= HOLD;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus random traffic, all checked
// every cycle against an age-ranked reference model of the redirect rules.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, imem_ready;
    logic        jump_req, branch_req, jr_req;
    logic [31:0] jump_target, branch_target, jr_target;
    logic [31:0] pc, redirect_tgt;
    logic        fetch_valid, flush_if, flush_id;
    logic [2:0]  pc_sel;

    int compare_count = 0;
    int fail_count    = 0;

    // model state: kinds are 0 none, 1 jump, 2 branch, 3 jr
    logic        m_boot, m_valid;
    logic [31:0] m_pc;
    int          m_pend_kind;
    logic [31:0] m_pend_tgt;

    pc_redirect_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
        .jump_req(jump_req), .jump_target(jump_target),
        .branch_req(branch_req), .branch_target(branch_target),
        .jr_req(jr_req), .jr_target(jr_target),
        .pc(pc), .fetch_valid(fetch_valid), .pc_sel(pc_sel),
        .redirect_tgt(redirect_tgt), .flush_if(flush_if), .flush_id(flush_id)
    );

    always #5 clk = ~clk;

    // Lowest rank wins: EX sources are older than the jump, and a live
    // request is newer than a buffered one of the same age class.
    function automatic void model_select(output int kind, output logic [31:0] tgt);
        int          c_kind [5];
        logic [31:0] c_tgt  [5];
        bit          c_on   [5];
        int          c_rank [5];
        int          best;
        c_on[0] = branch_req;  c_kind[0] = 2; c_tgt[0] = branch_target; c_rank[0] = 0;
        c_on[1] = jr_req;      c_kind[1] = 3; c_tgt[1] = jr_target;     c_rank[1] = 1;
        c_on[2] = jump_req;    c_kind[2] = 1; c_tgt[2] = jump_target;   c_rank[2] = 10;
        c_on[3] = (m_pend_kind != 0);
        c_kind[3] = m_pend_kind; c_tgt[3] = m_pend_tgt;
        c_rank[3] = (m_pend_kind == 1) ? 15 : 5;
        c_on[4] = 1'b0; c_kind[4] = 0; c_tgt[4] = 32'h0; c_rank[4] = 99;
        best = 4;
        for (int i = 0; i < 4; i++)
            if (c_on[i] && c_rank[i] < c_rank[best]) best = i;
        kind = c_on[best] ? c_kind[best] : 0;
        tgt  = c_on[best] ? c_tgt[best] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input bit s, input bit rdy, input bit j, input logic [31:0] jt,
                                  input bit b, input logic [31:0] bt, input bit r, input logic [31:0] rt);
        stall = s; imem_ready = rdy;
        jump_req = j; jump_target = jt;
        branch_req = b; branch_target = bt;
        jr_req = r; jr_target = rt;
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_valid = 1'b0; m_pc = RESET_PC;
        m_pend_kind = 0; m_pend_tgt = 32'h0;
    endtask

    // Checks the current cycle at the falling edge, then advances the model
    // across the next rising edge.
    task automatic check_output();
        int          kind;
        logic [31:0] tgt;
        logic [2:0]  exp_sel;
        bit          adv;
        @(negedge clk);
        model_select(kind, tgt);
        exp_sel = (kind == 1) ? 3'b001 : (kind == 2) ? 3'b010 : (kind == 3) ? 3'b100 : 3'b000;
        adv = !stall && imem_ready && !m_boot;
        check("pc", pc, m_pc);
        check("fetch_valid", {31'h0, fetch_valid}, {31'h0, m_valid});
        check("pc_sel", {29'h0, pc_sel}, {29'h0, exp_sel});
        check("redirect_tgt", redirect_tgt, tgt);
        check("flush_if", {31'h0, flush_if}, {31'h0, adv && kind != 0});
        check("flush_id", {31'h0, flush_id}, {31'h0, adv && (kind == 2 || kind == 3)});
        if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b1;
            m_pend_kind = kind; m_pend_tgt = tgt;
        end else if (adv) begin
            m_pc = (kind != 0) ? tgt : m_pc + PC_STEP;
            m_pend_kind = 0; m_pend_tgt = 32'h0;
        end else if (kind != 0) begin
            m_pend_kind = kind; m_pend_tgt = tgt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) check_output();
    endtask

    task automatic do_reset();
        apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
        check("rst_pc_sel", {29'h0, pc_sel}, 32'h0);
        check("rst_flush", {30'h0, flush_if, flush_id}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        do_reset();
        $display("[TB] boot and sequential fetch");
        idle(5);

        $display("[TB] jump, then branch beating a same-cycle jump");
        apply_stimulus(0, 1, 1, 32'h40, 0, 0, 0, 0);  check_output();
        apply_stimulus(0, 1, 1, 32'h100, 0, 0, 0, 0); check_output();
        apply_stimulus(0, 1, 1, 32'h100, 1, 32'h200, 0, 0); check_output();
        apply_stimulus(0, 1, 0, 0, 1, 32'h600, 1, 32'h700); check_output();
        idle(1);

        $display("[TB] redirects buffered across stall and imem not ready");
        apply_stimulus(1, 1, 1, 32'h300, 0, 0, 0, 0); check_output();
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);       check_output();
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);       check_output();
        idle(2);
        apply_stimulus(0, 0, 1, 32'h300, 0, 0, 0, 0); check_output();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h500); check_output();
        apply_stimulus(1, 1, 1, 32'h800, 0, 0, 0, 0); check_output();
        apply_stimulus(1, 1, 0, 0, 1, 32'h900, 0, 0); check_output();
        apply_stimulus(1, 0, 0, 0, 0, 0, 1, 32'hA02); check_output();
        idle(2);

        $display("[TB] PC wrap at top of address space");
        apply_stimulus(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); check_output();
        idle(2);

        $display("[TB] reset while holding a pending redirect");
        apply_stimulus(1, 1, 0, 0, 1, 32'h1234, 0, 0); check_output();
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);        check_output();
        do_reset();
        idle(3);

        $display("[TB] request arriving during boot");
        do_reset();
        apply_stimulus(0, 1, 1, 32'h2000, 0, 0, 0, 0); check_output();
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                           ($urandom_range(0, 5) == 0), $urandom,
                           ($urandom_range(0, 6) == 0), $urandom,
                           ($urandom_range(0, 6) == 0), $urandom);
            if (i == 200) do_reset();
            else check_output();
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
